// File: rtl/mux8_rr_sched_if.sv
// mux8_rr_sched_if: bundle between eight producer lanes, one consumer and the round-robin scheduler
// Signals: req[7:0]/din[8*DW-1:0] from the lanes, out_ready from the consumer,
// gnt[7:0]/sel[2:0]/out_valid/dout[DW-1:0] from the scheduler.
// Modports: master = lanes and consumer side, slave = scheduler side.
interface mux8_rr_sched_if #(
    parameter int DW = 1
);
    logic [7:0]      req;
    logic [8*DW-1:0] din;
    logic            out_ready;
    logic [7:0]      gnt;
    logic [2:0]      sel;
    logic            out_valid;
    logic [DW-1:0]   dout;
    modport master (output req, din, out_ready, input gnt, sel, out_valid, dout);
    modport slave (input req, din, out_ready, output gnt, sel, out_valid, dout);
endinterface

// File: rtl/mux8_rr_sched.sv
// mux8_rr_sched: round-robin burst scheduler steering one of eight lanes onto a valid/ready channel
// Ports: clk, rst_n (synchronous, active low), bus (slave modport of mux8_rr_sched_if).
// Parameters: DW lane data width, MAX_BURST accepted beats per grant (1..15).
module mux8_rr_sched #(
    parameter int DW        = 1,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    mux8_rr_sched_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state, state_n;
    logic [2:0]    sel_q, sel_n, ptr, ptr_n, base, win, idx;
    logic [7:0]    gnt_q, gnt_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          found, out_valid, acc, rel;

    // While granted, the search starts at the lane after the owner, which is exactly the ptr a release loads.
    assign base = (state == GRANT) ? sel_q + 3'd1 : ptr;

    // Downward scan so the lowest offset from base wins.
    always_comb begin
        found = 1'b0;
        win   = base;
        idx   = base;
        for (int k = 7; k >= 0; k--) begin
            idx = base + 3'(k);
            if (bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign out_valid     = (state == GRANT) && bus.req[sel_q];
    assign acc           = out_valid && bus.out_ready;
    assign rel           = (state == GRANT) && (!bus.req[sel_q] || (acc && cnt == CW'(MAX_BURST - 1)));
    assign bus.out_valid = out_valid;
    assign bus.dout      = out_valid ? bus.din[sel_q*DW +: DW] : '0;
    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;

    always_comb begin
        state_n = state;
        sel_n   = sel_q;
        gnt_n   = gnt_q;
        ptr_n   = rel ? sel_q + 3'd1 : ptr;
        cnt_n   = acc ? cnt + CW'(1) : cnt;
        if ((state == IDLE || rel) && found) begin
            state_n = GRANT;
            sel_n   = win;
            gnt_n   = 8'd1 << win;
            cnt_n   = '0;
        end else if (rel) begin
            state_n = IDLE;
            gnt_n   = '0;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sel_q <= '0;
            gnt_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sel_q <= sel_n;
            gnt_q <= gnt_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
        end
    end
endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb_mux8_rr_sched: directed checks of grant order, burst length, backpressure, early drop and reset
module tb_mux8_rr_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    int         total = 0;
    int         bad = 0;
    logic [3:0] ph = 4'd0;
    int         wrap_lane [12] = '{6, 6, 6, 6, 0, 0, 0, 0, 6, 6, 6, 6};
    logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    mux8_rr_sched_if #(.DW(8)) bus ();
    mux8_rr_sched #(.DW(8), .MAX_BURST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    // Lane data advances only after a cycle with out_ready high, so it is stable across stalls.
    task automatic drive(input logic r_n, input logic [7:0] r, input logic rdy);
        @(negedge clk);
        if (bus.out_ready === 1'b1) ph++;
        rst_n = r_n;
        bus.req = r;
        bus.out_ready = rdy;
        for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = {i[3:0], ph};
        #1;
    endtask

    task automatic cyc(input logic [7:0] r, input logic rdy);
        drive(1'b1, r, rdy);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] g, input logic [2:0] s, input logic v);
        chk({tag, " gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, " sel"}, 32'(bus.sel), 32'(s));
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(v));
        chk({tag, " dout"}, 32'(bus.dout), v ? 32'(bus.din[s*8 +: 8]) : 32'd0);
    endtask

    task automatic reset_seq(input string tag);
        drive(1'b0, 8'h00, 1'b1);
        cyc(8'h00, 1'b1);
        expect_out(tag, 8'h00, 3'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = 8'h00;
        bus.out_ready = 1'b0;
        bus.din = '0;
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        expect_out("reset", 8'h00, 3'd0, 1'b0);

        cyc(8'h08, 1'b1);
        expect_out("single req", 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            cyc(8'h08, 1'b1);
            expect_out("single beat", 8'h08, 3'd3, 1'b1);
        end
        cyc(8'h00, 1'b1);
        expect_out("single drop", 8'h08, 3'd3, 1'b0);
        cyc(8'h00, 1'b1);
        expect_out("single idle", 8'h00, 3'd3, 1'b0);

        reset_seq("rot rst");
        cyc(8'hFF, 1'b1);
        expect_out("rot req", 8'h00, 3'd0, 1'b0);
        for (int b = 0; b < 33; b++) begin
            cyc(8'hFF, 1'b1);
            expect_out("rot", 8'(1 << ((b / 4) % 8)), 3'((b / 4) % 8), 1'b1);
        end

        reset_seq("wrap rst");
        cyc(8'h40, 1'b1);
        expect_out("wrap req", 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 12; c++) begin
            cyc(8'h41, 1'b1);
            expect_out("wrap", 8'(1 << wrap_lane[c]), 3'(wrap_lane[c]), 1'b1);
        end

        reset_seq("bp rst");
        cyc(8'h22, 1'b1);
        expect_out("bp req", 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 7; c++) begin
            cyc(8'h22, rdy_pat[c]);
            expect_out("bp lane1", 8'h02, 3'd1, 1'b1);
        end
        cyc(8'h22, 1'b1);
        expect_out("bp handover", 8'h20, 3'd5, 1'b1);

        reset_seq("drop rst");
        cyc(8'h04, 1'b1);
        expect_out("drop req", 8'h00, 3'd0, 1'b0);
        cyc(8'h24, 1'b1);
        expect_out("drop beat1", 8'h04, 3'd2, 1'b1);
        cyc(8'h24, 1'b1);
        expect_out("drop beat2", 8'h04, 3'd2, 1'b1);
        cyc(8'h20, 1'b1);
        expect_out("drop fall", 8'h04, 3'd2, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(8'h24, 1'b1);
            expect_out("drop lane5", 8'h20, 3'd5, 1'b1);
        end
        cyc(8'h24, 1'b1);
        expect_out("drop back", 8'h04, 3'd2, 1'b1);

        reset_seq("mid rst");
        cyc(8'h10, 1'b1);
        expect_out("mid req", 8'h00, 3'd0, 1'b0);
        cyc(8'h10, 1'b1);
        expect_out("mid beat1", 8'h10, 3'd4, 1'b1);
        drive(1'b0, 8'h10, 1'b1);
        expect_out("mid beat2", 8'h10, 3'd4, 1'b1);
        cyc(8'h30, 1'b1);
        expect_out("mid after", 8'h00, 3'd0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(8'h30, 1'b1);
            expect_out("mid regrant", 8'h10, 3'd4, 1'b1);
        end
        cyc(8'h30, 1'b1);
        expect_out("mid next", 8'h20, 3'd5, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
